// File: rtl/cu_vertex_read_line_assembler_pkg.sv
// Shared types for the vertex read line assembler: input stream beats,
// the per-tag slot entry and the assembled output line.
package cu_vertex_read_line_assembler_pkg;

    localparam int unsigned NUM_VERTEX_READ_SLOTS = 32;
    localparam int unsigned HALF_W                = 512;
    localparam int unsigned TAG_W                 = 8;

    typedef enum logic [1:0] {
        RSP_DONE   = 2'd0,
        RSP_FAILED = 2'd1,
        RSP_RETRY  = 2'd2
    } rsp_code_e;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        rsp_code_e        code;
    } response_buffer_line_t;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [HALF_W-1:0] data;
    } read_write_data_line_t;

    typedef struct packed {
        logic                valid;
        logic [TAG_W-1:0]    tag;
        logic [2*HALF_W-1:0] data;
        logic                error;
    } vertex_read_line_t;

    typedef struct packed {
        logic              d0_ok;
        logic              d1_ok;
        logic              rsp_ok;
        logic              err;
        logic [TAG_W-1:0]  tag;
        logic [HALF_W-1:0] data0;
        logic [HALF_W-1:0] data1;
    } slot_entry_t;

endpackage

// File: rtl/cu_vertex_read_line_assembler_if.sv
// Upstream read streams and the downstream assembled-line handshake.
interface cu_vertex_read_line_assembler_if;
    import cu_vertex_read_line_assembler_pkg::*;

    response_buffer_line_t read_response_in;
    read_write_data_line_t read_data_0_in;
    read_write_data_line_t read_data_1_in;
    logic                  line_ready_in;
    logic                  line_valid_out;
    logic [TAG_W-1:0]      line_tag_out;
    logic [2*HALF_W-1:0]   line_data_out;
    logic                  line_error_out;

    modport master (
        output read_response_in, read_data_0_in, read_data_1_in, line_ready_in,
        input  line_valid_out, line_tag_out, line_data_out, line_error_out
    );

    modport slave (
        input  read_response_in, read_data_0_in, read_data_1_in, line_ready_in,
        output line_valid_out, line_tag_out, line_data_out, line_error_out
    );

endinterface

// File: rtl/cu_vertex_read_line_assembler_rr_slot_arbiter.sv
// Round-robin pick of the first complete slot at or after the pointer;
// the pointer moves past the grant whenever the grant is taken.
module rr_slot_arbiter #(
    parameter  int unsigned NUM_SLOTS = 32,
    localparam int unsigned SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic [NUM_SLOTS-1:0] complete,
    input  logic                 advance,
    output logic [NUM_SLOTS-1:0] grant,
    output logic [SLOT_W-1:0]    grant_idx,
    output logic                 any_grant
);

    logic [SLOT_W-1:0] ptr;
    logic [SLOT_W-1:0] scan_idx;

    always_comb begin
        grant_idx = '0;
        any_grant = 1'b0;
        scan_idx  = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            scan_idx = ptr + SLOT_W'(i);
            if (!any_grant && complete[scan_idx]) begin
                any_grant = 1'b1;
                grant_idx = scan_idx;
            end
        end
        grant = any_grant ? (NUM_SLOTS'(1) << grant_idx) : '0;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)       ptr <= '0;
        else if (advance) ptr <= grant_idx + SLOT_W'(1);
    end

endmodule

// File: rtl/cu_vertex_read_line_assembler.sv
// Collects both half-line beats and the response for a tag into a slot
// table and emits the assembled 1024-bit line over valid/ready.
module cu_vertex_read_line_assembler
    import cu_vertex_read_line_assembler_pkg::*;
#(
    parameter  int unsigned NUM_SLOTS = NUM_VERTEX_READ_SLOTS,
    localparam int unsigned SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic                           clock,
    input  logic                           rstn_in,
    input  logic                           enabled_in,
    cu_vertex_read_line_assembler_if.slave line_bus,
    output logic                           dup_error_out,
    output logic [SLOT_W:0]                pending_count_out
);

    logic rst_sync;
    always_ff @(posedge clock or negedge rstn_in) begin
        if (!rstn_in) rst_sync <= 1'b0;
        else          rst_sync <= 1'b1;
    end

    response_buffer_line_t rsp_q;
    read_write_data_line_t d0_q, d1_q;
    always_ff @(posedge clock or negedge rst_sync) begin
        if (!rst_sync) begin
            rsp_q <= '0;
            d0_q  <= '0;
            d1_q  <= '0;
        end else begin
            rsp_q       <= line_bus.read_response_in;
            rsp_q.valid <= line_bus.read_response_in.valid & enabled_in;
            d0_q        <= line_bus.read_data_0_in;
            d0_q.valid  <= line_bus.read_data_0_in.valid & enabled_in;
            d1_q        <= line_bus.read_data_1_in;
            d1_q.valid  <= line_bus.read_data_1_in.valid & enabled_in;
        end
    end

    slot_entry_t [NUM_SLOTS-1:0] slots, slots_next;
    logic [NUM_SLOTS-1:0]        complete, grant;
    logic [SLOT_W-1:0]           grant_idx, rsp_idx, d0_idx, d1_idx;
    logic                        any_grant, load, take, dup;
    vertex_read_line_t           line_q;

    assign rsp_idx = rsp_q.tag[SLOT_W-1:0];
    assign d0_idx  = d0_q.tag[SLOT_W-1:0];
    assign d1_idx  = d1_q.tag[SLOT_W-1:0];
    assign load    = !line_q.valid || line_bus.line_ready_in;
    assign take    = load && any_grant;

    always_comb begin
        for (int unsigned i = 0; i < NUM_SLOTS; i++)
            complete[i] = slots[i].d0_ok & slots[i].d1_ok & slots[i].rsp_ok;
    end

    rr_slot_arbiter #(.NUM_SLOTS(NUM_SLOTS)) u_arb (
        .clock     (clock),
        .rst_n     (rst_sync),
        .complete  (complete),
        .advance   (take),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // Grant clears first, so an arrival on the same edge starts a fresh occupancy.
    always_comb begin
        slots_next = slots;
        dup        = 1'b0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (take && grant[i]) begin
                slots_next[i].d0_ok  = 1'b0;
                slots_next[i].d1_ok  = 1'b0;
                slots_next[i].rsp_ok = 1'b0;
                slots_next[i].err    = 1'b0;
            end
        end
        if (rsp_q.valid) begin
            if (slots_next[rsp_idx].rsp_ok) dup = 1'b1;
            else begin
                slots_next[rsp_idx].rsp_ok = 1'b1;
                slots_next[rsp_idx].err    = (rsp_q.code != RSP_DONE);
                slots_next[rsp_idx].tag    = rsp_q.tag;
            end
        end
        if (d0_q.valid) begin
            if (slots_next[d0_idx].d0_ok) dup = 1'b1;
            else begin
                slots_next[d0_idx].d0_ok = 1'b1;
                slots_next[d0_idx].data0 = d0_q.data;
                slots_next[d0_idx].tag   = d0_q.tag;
            end
        end
        if (d1_q.valid) begin
            if (slots_next[d1_idx].d1_ok) dup = 1'b1;
            else begin
                slots_next[d1_idx].d1_ok = 1'b1;
                slots_next[d1_idx].data1 = d1_q.data;
                slots_next[d1_idx].tag   = d1_q.tag;
            end
        end
    end

    always_ff @(posedge clock or negedge rst_sync) begin
        if (!rst_sync) begin
            slots         <= '0;
            dup_error_out <= 1'b0;
            line_q        <= '0;
        end else begin
            slots         <= slots_next;
            dup_error_out <= dup;
            if (load) begin
                line_q.valid <= any_grant;
                if (any_grant) begin
                    line_q.tag   <= slots[grant_idx].tag;
                    line_q.data  <= {slots[grant_idx].data1, slots[grant_idx].data0};
                    line_q.error <= slots[grant_idx].err;
                end
            end
        end
    end

    always_comb begin
        pending_count_out = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++)
            if (slots[i].d0_ok | slots[i].d1_ok | slots[i].rsp_ok)
                pending_count_out = pending_count_out + (SLOT_W+1)'(1);
    end

    assign line_bus.line_valid_out = line_q.valid;
    assign line_bus.line_tag_out   = line_q.tag;
    assign line_bus.line_data_out  = line_q.data;
    assign line_bus.line_error_out = line_q.error;

endmodule

// File: tb/tb_cu_vertex_read_line_assembler.sv
// Directed scenarios plus a randomized run scored against a per-tag
// expectation table of issued lines.
module tb_cu_vertex_read_line_assembler;
    import cu_vertex_read_line_assembler_pkg::*;

    localparam int NS = 32;

    logic       clock;
    logic       rstn_in;
    logic       enabled_in;
    logic       dup_error_out;
    logic [5:0] pending_count_out;

    cu_vertex_read_line_assembler_if bus ();

    cu_vertex_read_line_assembler #(.NUM_SLOTS(NS)) dut (
        .clock             (clock),
        .rstn_in           (rstn_in),
        .enabled_in        (enabled_in),
        .line_bus          (bus),
        .dup_error_out     (dup_error_out),
        .pending_count_out (pending_count_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    bit          sb_on = 1'b0;
    bit          in_use  [NS];
    bit          sent_d0 [NS];
    bit          sent_d1 [NS];
    bit          sent_rsp[NS];
    logic [7:0]  exp_tag [NS];
    logic [511:0] exp_d0 [NS];
    logic [511:0] exp_d1 [NS];
    rsp_code_e   exp_code[NS];
    logic        exp_err [NS];
    int          done_lines = 0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic check_data(input string name, input logic [1023:0] obs, input logic [1023:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed_lo=%0h expected_lo=%0h", name, obs[127:0], exp[127:0]);
        end
    endtask

    function automatic logic [511:0] rnd_half();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic idle();
        bus.read_response_in = '0;
        bus.read_data_0_in   = '0;
        bus.read_data_1_in   = '0;
    endtask

    task automatic drive_d0(input logic [7:0] tag, input logic [511:0] d);
        bus.read_data_0_in = '{valid: 1'b1, tag: tag, data: d};
    endtask

    task automatic drive_d1(input logic [7:0] tag, input logic [511:0] d);
        bus.read_data_1_in = '{valid: 1'b1, tag: tag, data: d};
    endtask

    task automatic drive_rsp(input logic [7:0] tag, input rsp_code_e code);
        bus.read_response_in = '{valid: 1'b1, tag: tag, code: code};
    endtask

    // Scores a transfer happening on the coming edge, then advances one cycle.
    task automatic tick();
        int s;
        if (sb_on && bus.line_valid_out && bus.line_ready_in) begin
            s = int'(bus.line_tag_out[4:0]);
            check("sb_slot_live", 64'(in_use[s] && sent_d0[s] && sent_d1[s] && sent_rsp[s]), 64'd1);
            check("sb_tag", 64'(bus.line_tag_out), 64'(exp_tag[s]));
            check_data("sb_data", bus.line_data_out, {exp_d1[s], exp_d0[s]});
            check("sb_err", 64'(bus.line_error_out), 64'(exp_err[s]));
            in_use[s] = 1'b0;
            done_lines++;
        end
        if (sb_on) check("sb_no_dup", 64'(dup_error_out), 64'd0);
        @(posedge clock);
        #1;
    endtask

    task automatic drive_random_parts();
        int s;
        int c;
        int start;
        bit sent;
        for (int p = 0; p < 3; p++) begin
            if ($urandom_range(0, 9) < 7) begin
                start = $urandom_range(0, NS-1);
                s = -1;
                for (int k = 0; k < NS; k++) begin
                    c = (start + k) % NS;
                    sent = (p == 0) ? sent_d0[c] : (p == 1) ? sent_d1[c] : sent_rsp[c];
                    if (s < 0 && in_use[c] && !sent) s = c;
                end
                if (s >= 0) begin
                    case (p)
                        0: begin drive_d0(exp_tag[s], exp_d0[s]); sent_d0[s] = 1'b1; end
                        1: begin drive_d1(exp_tag[s], exp_d1[s]); sent_d1[s] = 1'b1; end
                        default: begin drive_rsp(exp_tag[s], exp_code[s]); sent_rsp[s] = 1'b1; end
                    endcase
                end
            end
        end
    endtask

    logic [511:0] a, b, c, e, f;
    int           issued;
    int           cyc;
    int           s_new;
    bit           busy;

    initial begin
        rstn_in    = 1'b1;
        enabled_in = 1'b1;
        bus.line_ready_in = 1'b1;
        idle();
        #2 rstn_in = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_valid", 64'(bus.line_valid_out), 64'd0);
        check("rst_tag", 64'(bus.line_tag_out), 64'd0);
        check_data("rst_data", bus.line_data_out, '0);
        check("rst_err", 64'(bus.line_error_out), 64'd0);
        check("rst_dup", 64'(dup_error_out), 64'd0);
        check("rst_pending", 64'(pending_count_out), 64'd0);
        rstn_in = 1'b1;
        tick(); tick();

        // Tag 5: data0, data1, DONE on consecutive cycles
        a = rnd_half(); b = rnd_half();
        drive_d0(8'd5, a); tick();
        idle(); drive_d1(8'd5, b); tick();
        idle(); drive_rsp(8'd5, RSP_DONE); tick();
        check("t5_pending_partial", 64'(pending_count_out), 64'd1);
        idle(); tick();
        check("t5_not_yet_valid", 64'(bus.line_valid_out), 64'd0);
        check("t5_pending_full", 64'(pending_count_out), 64'd1);
        tick();
        check("t5_valid", 64'(bus.line_valid_out), 64'd1);
        check("t5_tag", 64'(bus.line_tag_out), 64'd5);
        check_data("t5_data", bus.line_data_out, {b, a});
        check("t5_err", 64'(bus.line_error_out), 64'd0);
        check("t5_pending_after", 64'(pending_count_out), 64'd0);
        tick();
        check("t5_drained", 64'(bus.line_valid_out), 64'd0);

        // Tag 9: all three parts in one cycle
        a = rnd_half(); b = rnd_half();
        drive_d0(8'd9, a); drive_d1(8'd9, b); drive_rsp(8'd9, RSP_DONE); tick();
        idle(); tick();
        check("t9_early", 64'(bus.line_valid_out), 64'd0);
        tick();
        check("t9_valid", 64'(bus.line_valid_out), 64'd1);
        check("t9_tag", 64'(bus.line_tag_out), 64'd9);
        check_data("t9_data", bus.line_data_out, {b, a});
        tick();
        check("t9_single_line", 64'(bus.line_valid_out), 64'd0);
        tick();
        check("t9_still_idle", 64'(bus.line_valid_out), 64'd0);

        // Tags 3 and 7 complete together; consumer stalls
        a = rnd_half(); b = rnd_half(); e = rnd_half(); f = rnd_half();
        bus.line_ready_in = 1'b0;
        drive_d0(8'd3, a); drive_d1(8'd3, b); drive_rsp(8'd7, RSP_DONE); tick();
        idle(); drive_d0(8'd7, e); drive_d1(8'd7, f); drive_rsp(8'd3, RSP_DONE); tick();
        check("t37_pending_two", 64'(pending_count_out), 64'd2);
        idle(); tick();
        check("t37_not_yet_valid", 64'(bus.line_valid_out), 64'd0);
        check("t37_pending_complete", 64'(pending_count_out), 64'd2);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("t37_stall_valid", 64'(bus.line_valid_out), 64'd1);
            check("t37_stall_tag", 64'(bus.line_tag_out), 64'd3);
            check_data("t37_stall_data", bus.line_data_out, {b, a});
            check("t37_stall_pending", 64'(pending_count_out), 64'd1);
            tick();
        end
        check("t37_hold_tag", 64'(bus.line_tag_out), 64'd3);
        bus.line_ready_in = 1'b1;
        tick();
        check("t37_second_valid", 64'(bus.line_valid_out), 64'd1);
        check("t37_second_tag", 64'(bus.line_tag_out), 64'd7);
        check_data("t37_second_data", bus.line_data_out, {f, e});
        check("t37_pending_zero", 64'(pending_count_out), 64'd0);
        tick();
        check("t37_drained", 64'(bus.line_valid_out), 64'd0);

        // Tag 12: duplicate data0 before completion, then FAILED response
        a = rnd_half(); b = rnd_half(); c = rnd_half();
        drive_d0(8'd12, a); tick();
        idle(); drive_d0(8'd12, c); tick();
        check("t12_dup_quiet", 64'(dup_error_out), 64'd0);
        idle(); drive_d1(8'd12, b); drive_rsp(8'd12, RSP_FAILED); tick();
        check("t12_dup_pulse", 64'(dup_error_out), 64'd1);
        idle(); tick();
        check("t12_dup_one_cycle", 64'(dup_error_out), 64'd0);
        check("t12_not_yet_valid", 64'(bus.line_valid_out), 64'd0);
        tick();
        check("t12_valid", 64'(bus.line_valid_out), 64'd1);
        check("t12_tag", 64'(bus.line_tag_out), 64'd12);
        check_data("t12_data_original", bus.line_data_out, {b, a});
        check("t12_err", 64'(bus.line_error_out), 64'd1);
        tick();
        check("t12_drained", 64'(bus.line_valid_out), 64'd0);

        // Tag 2 while capture is disabled
        enabled_in = 1'b0;
        a = rnd_half();
        drive_d0(8'd2, a); drive_d1(8'd2, a); drive_rsp(8'd2, RSP_DONE); tick();
        idle(); enabled_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t2_no_line", 64'(bus.line_valid_out), 64'd0);
            check("t2_no_pending", 64'(pending_count_out), 64'd0);
        end

        // Reset with three partial slots
        a = rnd_half();
        drive_d0(8'd20, a); tick();
        drive_d0(8'd21, a); tick();
        drive_d0(8'd22, a); tick();
        idle(); tick(); tick();
        check("rst2_pending_before", 64'(pending_count_out), 64'd3);
        rstn_in = 1'b0;
        #1;
        check("rst2_valid", 64'(bus.line_valid_out), 64'd0);
        check("rst2_tag", 64'(bus.line_tag_out), 64'd0);
        check_data("rst2_data", bus.line_data_out, '0);
        check("rst2_err", 64'(bus.line_error_out), 64'd0);
        check("rst2_pending", 64'(pending_count_out), 64'd0);
        tick(); tick();
        rstn_in = 1'b1;
        tick(); tick();
        check("rst2_idle_after", 64'(bus.line_valid_out), 64'd0);
        check("rst2_pending_after", 64'(pending_count_out), 64'd0);
        a = rnd_half(); b = rnd_half();
        drive_d0(8'd4, a); drive_d1(8'd4, b); drive_rsp(8'd4, RSP_DONE); tick();
        idle(); tick(); tick();
        check("t4_valid", 64'(bus.line_valid_out), 64'd1);
        check("t4_tag", 64'(bus.line_tag_out), 64'd4);
        check_data("t4_data", bus.line_data_out, {b, a});
        tick();
        for (int i = 0; i < 3; i++) begin
            check("t4_only_line", 64'(bus.line_valid_out), 64'd0);
            tick();
        end

        // Randomized traffic with unique outstanding slots and random stalls
        for (int i = 0; i < NS; i++) in_use[i] = 1'b0;
        sb_on  = 1'b1;
        issued = 0;
        cyc    = 0;
        busy   = 1'b1;
        while ((issued < 80 || busy) && cyc < 5000) begin
            idle();
            if (issued < 80 && $urandom_range(0, 1) == 0) begin
                s_new = $urandom_range(0, NS-1);
                if (!in_use[s_new]) begin
                    in_use[s_new]   = 1'b1;
                    exp_tag[s_new]  = {3'($urandom()), 5'(s_new)};
                    exp_d0[s_new]   = rnd_half();
                    exp_d1[s_new]   = rnd_half();
                    exp_code[s_new] = ($urandom_range(0, 3) == 0) ? RSP_FAILED : RSP_DONE;
                    exp_err[s_new]  = (exp_code[s_new] != RSP_DONE);
                    sent_d0[s_new]  = 1'b0;
                    sent_d1[s_new]  = 1'b0;
                    sent_rsp[s_new] = 1'b0;
                    issued++;
                end
            end
            drive_random_parts();
            bus.line_ready_in = ($urandom_range(0, 3) != 0);
            tick();
            cyc++;
            busy = 1'b0;
            for (int i = 0; i < NS; i++) if (in_use[i]) busy = 1'b1;
        end
        idle();
        sb_on = 1'b0;
        check("rand_all_drained", 64'(busy), 64'd0);
        check("rand_lines_emitted", 64'(done_lines), 64'(issued));
        check("rand_pending_zero", 64'(pending_count_out), 64'd0);
        check("rand_output_idle", 64'(bus.line_valid_out), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
